// File: rtl/fb_capture_writer_if.sv
// Pixel-stream input and BRAM write-port bundle for fb_capture_writer.
// master = pixel source / BRAM side, slave = the capture writer itself.
interface fb_capture_writer_if #(
    parameter int unsigned ADDR_W = 17
) ();
    logic              in_valid;
    logic              in_sof;
    logic              in_eol;
    logic [11:0]       in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;

    modport master (
        output in_valid, in_sof, in_eol, in_data,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_sof, in_eol, in_data,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_capture_writer.sv
// Frame-buffer capture writer: arm/capture FSM driving a linear BRAM write port.
// Define FB_CAPTURE_DECIMATE_EN for 2:1 horizontal and vertical decimation.
module fb_capture_writer #(
    parameter int unsigned FB_W   = 320,
    parameter int unsigned FB_H   = 240,
    parameter int unsigned ADDR_W = 17
) (
    input  logic               clk25,
    input  logic               rst,
    input  logic               cap_start,
    input  logic               cap_continuous,
    fb_capture_writer_if.slave bus,
    output logic               busy,
    output logic               frame_done,
    output logic               sync_err,
    output logic [7:0]         frame_cnt
);

`ifdef FB_CAPTURE_DECIMATE_EN
    localparam bit DecimateEn = 1'b1;
`else
    localparam bit DecimateEn = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_W * FB_H - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_e;

    state_e            state_q;
    logic              col_par_q;
    logic              line_par_q;
    logic [ADDR_W-1:0] kept_q;

    logic              take;
    logic              col_cur;
    logic              line_cur;
    logic              keep;
    logic [ADDR_W-1:0] base;

    // An in_sof pixel restarts the frame: it is pixel 0 with both parities clear.
    always_comb begin
        take     = bus.in_valid &&
                   ((state_q == StCapture) || ((state_q == StArmed) && bus.in_sof));
        col_cur  = bus.in_sof ? 1'b0 : col_par_q;
        line_cur = bus.in_sof ? 1'b0 : line_par_q;
        base     = bus.in_sof ? '0 : kept_q;
        keep     = DecimateEn ? (!col_cur && !line_cur) : 1'b1;
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q     <= StIdle;
            col_par_q   <= 1'b0;
            line_par_q  <= 1'b0;
            kept_q      <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            bus.wr_en  <= 1'b0;
            frame_done <= 1'b0;
            if (cap_start) begin
                sync_err <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (cap_start) begin
                        state_q <= StArmed;
                    end
                end
                StArmed, StCapture: begin
                    if (take) begin
                        if (bus.in_sof) begin
                            // Set after the cap_start clear so a same-cycle restart still flags.
                            if (state_q == StCapture) begin
                                sync_err <= 1'b1;
                            end
                            state_q <= StCapture;
                        end
                        col_par_q  <= bus.in_eol ? 1'b0 : ~col_cur;
                        line_par_q <= bus.in_eol ? ~line_cur : line_cur;
                        if (keep) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= base;
                            bus.wr_data <= bus.in_data;
                            kept_q      <= base + ADDR_W'(1);
                            if (base == LastAddr) begin
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 8'd1;
                                state_q    <= cap_continuous ? StArmed : StIdle;
                            end
                        end else begin
                            kept_q <= base;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_capture_writer.sv
// Randomized self-checking bench for fb_capture_writer on a reduced 8x6 frame buffer,
// compared cycle by cycle against an x/y-coordinate reference model.
module tb_fb_capture_writer;

    localparam int unsigned FB_W   = 8;
    localparam int unsigned FB_H   = 6;
    localparam int unsigned ADDR_W = 6;
    localparam int          NPIX   = FB_W * FB_H;
`ifdef FB_CAPTURE_DECIMATE_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif
    localparam int SRC_W   = DEC ? 2 * FB_W : FB_W;
    localparam int SRC_H   = DEC ? 2 * FB_H : FB_H;
    localparam int SRC_PIX = SRC_W * SRC_H;

    logic       clk25 = 1'b0;
    logic       rst;
    logic       cap_start;
    logic       cap_continuous;
    logic       busy;
    logic       frame_done;
    logic       sync_err;
    logic [7:0] frame_cnt;

    fb_capture_writer_if #(.ADDR_W(ADDR_W)) bus ();

    fb_capture_writer #(
        .FB_W  (FB_W),
        .FB_H  (FB_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk25         (clk25),
        .rst           (rst),
        .cap_start     (cap_start),
        .cap_continuous(cap_continuous),
        .bus           (bus),
        .busy          (busy),
        .frame_done    (frame_done),
        .sync_err      (sync_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk25 = ~clk25;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    // Reference model: mode 0 idle, 1 armed, 2 capturing; source coordinates x/y.
    int m_mode = 0;
    int m_x    = 0;
    int m_y    = 0;
    int m_kept = 0;
    int e_cnt  = 0;
    bit e_err  = 1'b0;
    bit e_wr_en;
    bit e_done;
    int e_addr;
    int e_data;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit start, input bit v, input bit sof, input bit eol,
                        input logic [11:0] d);
        rst          = r;
        cap_start    = start;
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_eol   = eol;
        bus.in_data  = d;
        @(posedge clk25);
        e_wr_en = 1'b0;
        e_done  = 1'b0;
        if (r) begin
            m_mode = 0;
            m_kept = 0;
            e_err  = 1'b0;
            e_cnt  = 0;
        end else begin
            if (start) e_err = 1'b0;
            if (m_mode == 0) begin
                if (start) m_mode = 1;
            end else if (v && (m_mode == 2 || sof)) begin
                if (sof) begin
                    if (m_mode == 2) e_err = 1'b1;
                    m_mode = 2;
                    m_x    = 0;
                    m_y    = 0;
                    m_kept = 0;
                end
                if (!DEC || ((m_x % 2 == 0) && (m_y % 2 == 0))) begin
                    e_wr_en = 1'b1;
                    e_addr  = m_kept;
                    e_data  = int'(d);
                    m_kept++;
                    if (m_kept == NPIX) begin
                        e_done = 1'b1;
                        e_cnt  = (e_cnt + 1) % 256;
                        m_mode = cap_continuous ? 1 : 0;
                    end
                end
                if (eol) begin
                    m_x = 0;
                    m_y++;
                end else begin
                    m_x++;
                end
            end
        end
        #1;
        check("wr_en", int'(bus.wr_en), int'(e_wr_en));
        if (e_wr_en) begin
            check("wr_addr", int'(bus.wr_addr), e_addr);
            check("wr_data", int'(bus.wr_data), e_data);
        end
        if (r) begin
            check("rst_wr_addr", int'(bus.wr_addr), 0);
            check("rst_wr_data", int'(bus.wr_data), 0);
        end
        check("frame_done", int'(frame_done), int'(e_done));
        check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
        check("sync_err", int'(sync_err), int'(e_err));
        check("frame_cnt", int'(frame_cnt), e_cnt);
        if (bus.wr_en === 1'b1) n_writes++;
    endtask

    // Source pixels first..last-1 of a row-major frame; pixel 0 carries in_sof.
    task automatic send_frame(input int first, input int last, input bit gaps);
        for (int i = first; i < last; i++) begin
            if (gaps) begin
                int ng = $urandom_range(2, 0);
                for (int g = 0; g < ng; g++) begin
                    step(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 12'($urandom));
                end
            end
            step(1'b0, 1'b0, 1'b1, (i == 0), ((i % SRC_W) == SRC_W - 1), 12'($urandom));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    endtask

    initial begin
        cap_continuous = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        idle(3);

        // Single shot, then an unarmed frame must not be written.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        n_writes = 0;
        send_frame(0, SRC_PIX, 1'b0);
        idle(2);
        check("single_writes", n_writes, NPIX);
        check("single_cnt", int'(frame_cnt), 1);
        check("single_idle", int'(busy), 0);
        n_writes = 0;
        send_frame(0, SRC_PIX, 1'b0);
        check("unarmed_writes", n_writes, 0);

        // Gapped input.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        n_writes = 0;
        send_frame(0, SRC_PIX, 1'b1);
        idle(2);
        check("gapped_writes", n_writes, NPIX);

        // Mid-frame restart, then cap_start clears sync_err (leaving the FSM armed).
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        send_frame(0, SRC_PIX / 2, 1'b1);
        send_frame(0, SRC_PIX, 1'b0);
        check("sof_err_set", int'(sync_err), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        check("sof_err_clr", int'(sync_err), 0);

        // cap_start together with a mid-frame in_sof leaves sync_err set.
        send_frame(0, SRC_PIX / 3, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'($urandom));
        send_frame(1, SRC_PIX, 1'b0);
        check("start_sof_err", int'(sync_err), 1);

        // cap_start with in_sof while idle, then non-sof pixels while armed: no writes.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'($urandom));
        n_writes = 0;
        send_frame(1, SRC_PIX / 2, 1'b1);
        check("armed_nosof", n_writes, 0);
        send_frame(0, SRC_PIX, 1'b1);
        check("armed_then_sof", n_writes, NPIX);

        // Continuous capture over three frames.
        cap_continuous = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        n_writes = 0;
        for (int f = 0; f < 3; f++) send_frame(0, SRC_PIX, 1'b1);
        check("cont_writes", n_writes, 3 * NPIX);
        check("cont_busy", int'(busy), 1);
        cap_continuous = 1'b0;
        send_frame(0, SRC_PIX, 1'b0);
        check("cont_stop", int'(busy), 0);

        // Reset in the middle of a capture.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        send_frame(0, SRC_PIX / 2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'($urandom));
        check("rst_cnt", int'(frame_cnt), 0);
        n_writes = 0;
        send_frame(0, SRC_PIX, 1'b1);
        check("rst_nowrite", n_writes, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_capture_writer.md
# fb_capture_writer

Frame-buffer writer feeding the 320x240 RGB444 BRAM that the VGA scan-out side reads. It accepts a source-paced pixel stream with start-of-frame and end-of-line markers, optionally decimates 2:1 in both axes, and drives the BRAM write port with linear addresses 0..FB_W*FB_H-1. A small arm/capture state machine supports single-shot or continuous capture.

## Interface
- FB_W, 320, stored pixels per line
- FB_H, 240, stored lines per frame
- ADDR_W, 17, BRAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H
- clk25  in  1  pixel/system clock, all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- cap_start  in  1  one-cycle pulse: arm capture of next frame, clears sync_err
- cap_continuous  in  1  level: re-arm automatically after each completed frame
- in_valid  in  1  pixel present this cycle; no backpressure
- in_sof  in  1  qualifies in_valid: first pixel of frame
- in_eol  in  1  qualifies in_valid: last pixel of line
- in_data  in  12  pixel, R[11:8] G[7:4] B[3:0]
- wr_en  out  1  BRAM write strobe
- wr_addr  out  ADDR_W  BRAM write address
- wr_data  out  12  BRAM write data
- busy  out  1  state is ARMED or CAPTURE
- frame_done  out  1  one-cycle pulse with final write of a frame
- sync_err  out  1  sticky: in_sof seen mid-frame
- frame_cnt  out  8  completed frames, wraps 255->0

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE: all pixels ignored; cap_start -> ARMED.
- ARMED: pixels without in_sof ignored; accepted in_sof pixel -> CAPTURE, that pixel is frame pixel 0 (x=0,y=0).
- CAPTURE: each accepted pixel passes the keep filter; kept pixels written at addr = count of kept pixels so far this frame.
- Keep filter: column parity toggles per accepted pixel, clears on in_eol; line parity toggles on in_eol, clears on in_sof. Pixel kept when both parities 0 (decimation on) or always (off).
- Completion: write of addr FB_W*FB_H-1 -> frame_done, frame_cnt+1, next state ARMED if cap_continuous else IDLE.
- in_sof in CAPTURE before completion: sync_err<=1, address restarts at 0 with this pixel as pixel 0, stays CAPTURE.
- cap_start in ARMED/CAPTURE ignored except clearing sync_err; cap_start and mid-frame in_sof same cycle: sync_err ends 1.
- Address never exceeds FB_W*FB_H-1; extra lines/pixels after completion discarded until next arm.
- in_eol count not checked; short/long lines only shift addresses.

## Timing
- Reset values: state IDLE, wr_en 0, wr_addr 0, wr_data 0, busy 0, frame_done 0, sync_err 0, frame_cnt 0, parities 0.
- Kept pixel accepted cycle N -> wr_en=1, wr_addr, wr_data valid cycle N+1 (one register stage); wr_en otherwise 0.
- frame_done coincides with final wr_en; state already ARMED/IDLE in that cycle (busy reflects it).
- cap_start in cycle N (IDLE) -> ARMED in N+1; an in_sof pixel in cycle N is not captured.
- Throughput: one pixel per cycle sustained.
- rst mid-frame: next cycle all outputs at reset values, pending write dropped; BRAM contents untouched.

## Configuration
- FB_CAPTURE_DECIMATE_EN defined: 2:1 horizontal and vertical decimation; source frame is 2*FB_W x 2*FB_H (640x480 default), even columns of even lines stored.
- Undefined: no decimation; source frame is FB_W x FB_H, every accepted pixel in CAPTURE stored.

## Test plan
- Single-shot, decimation off: cap_start, 320x240 frame with data=addr[11:0] -> 76800 writes, addr 0..76799 in order, data matches, frame_done once with addr 76799, frame_cnt=1, then IDLE; second frame produces no writes.
- Continuous, decimation on: cap_continuous=1, three 640x480 frames -> 76800 writes each, stored pixel (x,y) = source (2x,2y), frame_cnt=3, busy stays 1.
- Gapped input: random in_valid ~50% -> identical addr/data sequence, each write exactly one cycle after its pixel.
- Mid-frame in_sof after 1000 writes -> sync_err=1, next write addr 0; full frame then completes; cap_start clears sync_err.
- Pixels before in_sof while ARMED, and in_sof same cycle as cap_start in IDLE -> no writes until next in_sof.
- rst asserted during CAPTURE at addr 500 -> next cycle wr_en 0, state IDLE, all outputs reset; no further writes without cap_start.
